// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [5:0] MD_ITERS      = 6'd32;

    // Decode helper for the ID stage: true for an M-extension register-register op.
    function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
    endfunction

    // op_a is a signed operand for MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // op_b is a signed operand for MULH, DIV and REM.
    function automatic logic op_b_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage handshake between the ID/EX pipeline register and the mul/div unit.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in, flush,
        input  busy, result, result_valid, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, flush,
        output busy, result, result_valid, rd_out
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// One radix-2 step: shift-add for multiply, restore-subtract for divide.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] trial_rem;

    // Multiply keeps the multiplier in acc_lo; divide shifts the dividend out of acc_lo.
    always_comb begin
        add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        trial_rem = {acc_hi, acc_lo[XLEN-1]};
        if (is_div) begin
            if (trial_rem >= {1'b0, operand}) begin
                hi_next = trial_rem[XLEN-1:0] - operand;
                lo_next = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = trial_rem[XLEN-1:0];
                lo_next = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = add_sum[XLEN:1];
            lo_next = {add_sum[0], acc_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, step counter, sign handling and result registers.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    ex_muldiv_unit_if.slave md
);

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    md_op_e          op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic            result_valid_q, result_valid_d;

    md_op_e          in_op;
    logic            in_div, in_sa, in_sb, fast_hit;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic [XLEN-1:0] core_hi, core_lo, fixed_res;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .is_div  (op_q[2]),
        .acc_hi  (hi_q),
        .acc_lo  (lo_q),
        .operand (mcand_q),
        .hi_next (core_hi),
        .lo_next (core_lo)
    );

    // Operand magnitudes, sign flags and the divide special cases decided at accept time.
    always_comb begin
        in_op  = md_op_e'(md.funct3);
        in_div = md.funct3[2];
        in_sa  = op_a_signed(in_op) && md.op_a[XLEN-1];
        in_sb  = op_b_signed(in_op) && md.op_b[XLEN-1];
        a_mag  = in_sa ? -md.op_a : md.op_a;
        b_mag  = in_sb ? -md.op_b : md.op_b;
        fast_hit = 1'b0;
        fast_res = ZERO;
        if (in_div && (md.op_b == ZERO)) begin
            fast_hit = 1'b1;
            fast_res = md.funct3[1] ? md.op_a : ALL_ONES;
        end else if (((in_op == MD_DIV) || (in_op == MD_REM)) &&
                     (md.op_a == MIN_INT) && (md.op_b == ALL_ONES)) begin
            fast_hit = 1'b1;
            fast_res = md.funct3[1] ? ZERO : MIN_INT;
        end else begin
            fast_hit = 1'b0;
            fast_res = ZERO;
        end
    end

    // Sign fix and result select, applied to the outcome of the final step.
    always_comb begin
        prod     = {core_hi, core_lo};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        quo_fix  = (sa_q ^ sb_q) ? -core_lo : core_lo;
        rem_fix  = sa_q ? -core_hi : core_hi;
        case (op_q)
            MD_MUL:                       fixed_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fixed_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fixed_res = quo_fix;
            MD_REM, MD_REMU:              fixed_res = rem_fix;
            default:                      fixed_res = ZERO;
        endcase
    end

    // Next-state logic; flush always returns to IDLE without producing a result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            MD_IDLE: begin
                if (md.start && !md.flush) begin
                    op_d  = in_op;
                    rd_d  = md.rd_in;
                    sa_d  = in_sa;
                    sb_d  = in_sb;
                    cnt_d = 6'd0;
                    hi_d  = ZERO;
                    if (in_div) begin
                        lo_d    = a_mag;
                        mcand_d = b_mag;
                    end else begin
                        lo_d    = b_mag;
                        mcand_d = a_mag;
                    end
                    if (fast_hit) begin
                        state_d  = MD_DONE;
                        result_d = fast_res;
                        rd_out_d = md.rd_in;
                    end else begin
                        state_d = MD_BUSY;
                    end
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (md.flush) begin
                    state_d = MD_IDLE;
                end else begin
                    hi_d  = core_hi;
                    lo_d  = core_lo;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == (MD_ITERS - 6'd1)) begin
                        state_d  = MD_DONE;
                        result_d = fixed_res;
                        rd_out_d = rd_q;
                    end else begin
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        result_valid_d = (state_d == MD_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= MD_IDLE;
            cnt_q          <= 6'd0;
            op_q           <= MD_MUL;
            rd_q           <= 5'd0;
            hi_q           <= ZERO;
            lo_q           <= ZERO;
            mcand_q        <= ZERO;
            sa_q           <= 1'b0;
            sb_q           <= 1'b0;
            result_q       <= ZERO;
            rd_out_q       <= 5'd0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            rd_q           <= rd_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            mcand_q        <= mcand_d;
            sa_q           <= sa_d;
            sb_q           <= sb_d;
            result_q       <= result_d;
            rd_out_q       <= rd_out_d;
            result_valid_q <= result_valid_d;
        end
    end

    // busy drops in the flush cycle and in DONE so ID/EX can advance.
    assign md.busy         = ((state_q == MD_IDLE) && md.start && !md.flush) ||
                             ((state_q == MD_BUSY) && !md.flush);
    assign md.result       = result_q;
    assign md.result_valid = result_valid_q;
    assign md.rd_out       = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M vectors, fast paths, flush and reset abort.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [4:0]  rd;
        bit          fast;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_valid = -1;
    exp_t sb_q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_muldiv_unit_if #(.XLEN(32)) md_if ();

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (md_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && md_if.result_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result %h rd %0d with nothing expected (cycle %0d)",
                         md_if.result, md_if.rd_out, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", md_if.result, e.res);
                check("rd_out", {27'd0, md_if.rd_out}, {27'd0, e.rd});
                check("valid_cycle", cyc, e.due);
            end
            last_valid = cyc;
        end
    end

    // Drives one instruction from ID/EX and holds it until the unit releases the stall.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit fast,
                         output int nbusy);
        exp_t e;
        int   k;
        md_if.start  = 1'b1;
        md_if.funct3 = f3;
        md_if.op_a   = a;
        md_if.op_b   = b;
        md_if.rd_in  = rd;
        e.res = exp;
        e.rd  = rd;
        e.due = cyc + (fast ? 1 : 33);
        sb_q.push_back(e);
        nbusy = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (md_if.busy) nbusy++;
            else break;
        end
        check("stall_released", (k < 200) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1;
        md_if.start = 1'b0;
    endtask

    initial begin
        int nb;
        int v1;
        md_if.start  = 1'b0;
        md_if.funct3 = 3'b000;
        md_if.op_a   = 32'd0;
        md_if.op_b   = 32'd0;
        md_if.rd_in  = 5'd0;
        md_if.flush  = 1'b0;

        vecs = '{
            '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd1,  1'b0},
            '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd2,  1'b0},
            '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  1'b0},
            '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd4,  1'b0},
            '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 5'd5,  1'b0},
            '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 5'd6,  1'b0},
            '{3'b101, 32'd100,       32'd7,         32'd14,        5'd7,  1'b0},
            '{3'b111, 32'd100,       32'd7,         32'd2,         5'd8,  1'b0},
            '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd9,  1'b1},
            '{3'b110, 32'd5,         32'd0,         32'd5,         5'd10, 1'b1},
            '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd11, 1'b1},
            '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 5'd12, 1'b1}
        };

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, md_if.busy}, 32'd0);
        check("rst_result", md_if.result, 32'd0);
        check("rst_valid",  {31'd0, md_if.result_valid}, 32'd0);
        check("rst_rd_out", {27'd0, md_if.rd_out}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, issued back to back as ID/EX would present them.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].fast, nb);
            if (i == 0) check("mul_busy_cycles", nb, 32'd33);
            if (i == 8) check("fast_busy_cycles", nb, 32'd1);
        end

        // Flush a DIV at C10: busy must drop at once and the unit must be idle at C11.
        md_if.start  = 1'b1;
        md_if.funct3 = 3'b100;
        md_if.op_a   = 32'd100;
        md_if.op_b   = 32'd7;
        md_if.rd_in  = 5'd13;
        repeat (10) @(posedge clk);
        #1;
        md_if.flush = 1'b1;
        @(negedge clk);
        check("flush_busy", {31'd0, md_if.busy}, 32'd0);
        @(posedge clk);
        #1;
        md_if.flush = 1'b0;
        md_if.start = 1'b0;
        @(negedge clk);
        check("idle_after_flush", {31'd0, md_if.busy}, 32'd0);
        @(posedge clk);
        #1;
        issue(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd14, 32'h2345_6780, 1'b0, nb);
        check("mul_after_flush_busy", nb, 32'd33);

        // Reset mid-operation at C15 clears every output without waiting for a clock.
        md_if.start  = 1'b1;
        md_if.funct3 = 3'b000;
        md_if.op_a   = 32'd3;
        md_if.op_b   = 32'd5;
        md_if.rd_in  = 5'd15;
        repeat (15) @(posedge clk);
        #1;
        reset_n     = 1'b0;
        md_if.start = 1'b0;
        #1;
        check("async_rst_busy",   {31'd0, md_if.busy}, 32'd0);
        check("async_rst_result", md_if.result, 32'd0);
        check("async_rst_valid",  {31'd0, md_if.result_valid}, 32'd0);
        check("async_rst_rd_out", {27'd0, md_if.rd_out}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue(3'b000, 32'd6, 32'd7, 5'd16, 32'd42, 1'b0, nb);
        v1 = last_valid;
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'h0000_0001, 1'b0, nb);
        check("b2b_spacing", last_valid - v1, 32'd34);

        repeat (40) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
